// File: rtl/vga_scan_gen_pkg.sv
// vga_pkg: 640x480@60 timing constants and coordinate type shared by the scan generator.
package vga_pkg;
  localparam int COORD_W  = 10;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/vga_scan_gen_if.sv
// vga_scan_if: scan outputs (pixel enable, coordinates, syncs) from generator to region/sprite blocks.
interface vga_scan_if;
  import vga_pkg::*;
  logic   pixel_ce;
  coord_t DrawX;
  coord_t DrawY;
  logic   hs;
  logic   vs;
  logic   blank_n;
  logic   frame_start;
  modport master (output pixel_ce, DrawX, DrawY, hs, vs, blank_n, frame_start);
  modport slave  (input  pixel_ce, DrawX, DrawY, hs, vs, blank_n, frame_start);
endinterface

// File: rtl/vga_scan_gen_scan_counter.sv
// scan_counter: 0..MAX wrap counter advancing on en; wrap flags the enabled terminal count.
module scan_counter
  import vga_pkg::*;
#(
  parameter int MAX = 799
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   clear,
  output coord_t count,
  output logic   wrap
);
  assign wrap = en && count == coord_t'(MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster scan generator (pixel enable, DrawX/DrawY, hs/vs/blank_n, frame_start).
// Define VGA_SYNC_DELAY_EN to delay hs/vs/blank_n by one pixel for ROM-latency alignment.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic       Clk,
  input  logic       Reset_n,
  vga_scan_if.master scan
);
  localparam int     HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int     DW     = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam coord_t HS_ON  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_OFF = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_ON  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_OFF = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t HA     = coord_t'(H_ACTIVE);
  localparam coord_t VA     = coord_t'(V_ACTIVE);
  logic [DW-1:0] div, div_nx;
  logic pce, hw, vw, hs_r, vs_r, bn_r, fs_r;
  coord_t hx, vy, nx, ny;
  scan_counter #(.MAX(HT - 1)) u_h (
    .clk(Clk), .rst_n(Reset_n), .en(pce), .clear(1'b0), .count(hx), .wrap(hw)
  );
  scan_counter #(.MAX(VT - 1)) u_v (
    .clk(Clk), .rst_n(Reset_n), .en(hw), .clear(1'b0), .count(vy), .wrap(vw)
  );
  // Syncs are computed from the post-edge coordinates so they move with DrawX/DrawY.
  always_comb begin
    div_nx = div == DW'(CLK_DIV - 1) ? '0 : div + 1'b1;
    nx     = hw ? '0 : pce ? hx + 1'b1 : hx;
    ny     = vw ? '0 : hw ? vy + 1'b1 : vy;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      div  <= '0;
      pce  <= 1'b0;
      hs_r <= 1'b1;
      vs_r <= 1'b1;
      bn_r <= 1'b1;
      fs_r <= 1'b0;
    end else begin
      div  <= div_nx;
      pce  <= div_nx == DW'(CLK_DIV - 1);
      hs_r <= !(nx >= HS_ON && nx < HS_OFF);
      vs_r <= !(ny >= VS_ON && ny < VS_OFF);
      bn_r <= nx < HA && ny < VA;
      fs_r <= vw;
    end
  assign scan.pixel_ce    = pce;
  assign scan.DrawX       = hx;
  assign scan.DrawY       = vy;
  assign scan.frame_start = fs_r;
`ifdef VGA_SYNC_DELAY_EN
  logic hs_d, vs_d, bn_d;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) {hs_d, vs_d, bn_d} <= 3'b110;
    else if (pce) {hs_d, vs_d, bn_d} <= {hs_r, vs_r, bn_r};
  assign scan.hs      = hs_d;
  assign scan.vs      = vs_d;
  assign scan.blank_n = bn_d;
`else
  assign scan.hs      = hs_r;
  assign scan.vs      = vs_r;
  assign scan.blank_n = bn_r;
`endif
endmodule
